traffic_light: RTL and testbench
================================

# traffic_light

Single-intersection traffic-light sequencer that drives a 2-bit encoded lamp output. In automatic mode it cycles RED → GREEN → YELLOW → RED, holding each phase for a switch-programmed number of ticks. In manual mode the timer is frozen and an operator pulse steps the sequence one phase at a time. The block sits between board switches/buttons and the lamp driver, with one clock domain.

## Interface
Parameters:
- TICK_CYCLES, default 10: clock cycles per duration tick; must be ≥ 1. Set to the clock frequency on hardware for 1 s ticks.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: asynchronous active-low reset.
- sw_led, input, 12: phase durations in ticks.
  - [11:8] = RED.
  - [7:4] = GREEN.
  - [3:0] = YELLOW.
- controll_led, input, 1: manual step request, asynchronous to clk. Each rising edge advances one phase in manual mode.
- sw_mode, input, 1: 0 = automatic timed cycling; 1 = manual stepping.
- led, output, 2: registered lamp code.
  - 2'b11 = RED.
  - 2'b01 = GREEN.
  - 2'b10 = YELLOW.
  - 2'b00 is never driven outside reset.

## Operation
- **States:** RED, GREEN, YELLOW. Next-state order is fixed: RED→GREEN→YELLOW→RED.
- **Counters:**
  - Prescaler `pre` counts 0..TICK_CYCLES-1 and produces a one-cycle tick when `pre` = TICK_CYCLES-1.
  - Phase counter `rem` is 4-bit.
- **Phase entry:** on entering any phase (including reset exit):
  - `pre` ← 0.
  - `rem` ← that phase's duration field, sampled at that moment. A field value of 0 is loaded as 1 (minimum 1 tick).
  - Changes to sw_led mid-phase do not affect the current phase.
- **Automatic mode (sw_mode=0):**
  - On each tick, if `rem` = 1, advance to the next phase and reload; otherwise `rem` ← `rem` - 1.
  - Resulting phase length is exactly max(dur,1)·TICK_CYCLES cycles.
- **Manual mode (sw_mode=1):**
  - `pre` and `rem` are frozen, so no timed advance occurs.
  - controll_led passes through a 2-flop synchronizer plus an edge register, all reset to 0.
  - A detected rising edge advances exactly one phase and performs the phase-entry reload.
  - Holding controll_led high gives one step only.
  - Edges of controll_led while sw_mode=0 are ignored. The edge register still tracks, so switching to manual with the button already held causes no step.
- **Mode change 1→0:** the current phase restarts its full duration: `pre` ← 0 and `rem` is reloaded from the sampled sw_led field. sw_mode is used directly (a quasi-static switch), not synchronized.
- **Reset:** asynchronous assertion (rst=0) immediately forces:
  - state = RED, led = 2'b11.
  - `pre` = 0, `rem` = 1.
  - Synchronizer/edge flops = 0.

  On the first clock after deassertion, `rem` loads the RED field; this counts as phase entry.
- **Reset mid-phase:** abandons the phase; the sequence always restarts at RED.

## Timing
- led is a register updated on the same clock edge as the state change. No combinational path exists from any input to led.
- **Automatic:** with reset released before clock edge E0, RED spans max(R,1)·TICK_CYCLES cycles counted from E0. GREEN and YELLOW follow with the same rule. Full period = (max(R,1)+max(G,1)+max(Y,1))·TICK_CYCLES cycles.
- **Manual:** led changes on the 3rd rising clk edge after controll_led rises, given setup is met at the 1st edge. controll_led must be held high and then low for ≥ 3 cycles each for every step to register.
- **Tick and manual edge in the same cycle:** cannot coincide, because the mode selects which one is active.

## Test plan
- **Automatic cycle:** TICK_CYCLES=10, sw_led=12'hFF2, sw_mode=0, controll_led=0, reset low 50 cycles then high.
  - led=11 for 150 cycles, then 01 for 150 cycles, then 10 for 20 cycles, then 11.
  - Period 320 cycles, repeated over 4000 cycles.
- **Reset values:** assert rst=0 asynchronously mid-GREEN → led=11 immediately, without waiting for a clock. After release, a full 150-cycle RED follows.
- **Zero duration:** sw_led=12'h101, i.e. GREEN field=0 → RED 10 cycles, GREEN 10 cycles (treated as 1 tick), YELLOW 10 cycles.
- **Duration sampling:** change sw_led from FF2 to 3F2 mid-RED → current RED still lasts 150 cycles. The next RED lasts 30 cycles.
- **Manual stepping:** sw_mode=1 during RED; pulse controll_led high 5 cycles, three times with 5-cycle gaps.
  - led steps 11→01→10→11, each change 3 cycles after the rising edge.
  - No timed change for 1000 idle cycles.
  - A level held high for 100 cycles gives a single step.
- **Return to automatic:** sw_mode 1→0 while in GREEN with G=15 → GREEN lasts exactly 150 further cycles, then YELLOW 20 cycles.

Source files
------------

// File: rtl/traffic_light.sv
`timescale 1ns/1ps
// traffic_light: RED -> GREEN -> YELLOW -> RED sequencer. Phase lengths come from
// sw_led in ticks (auto mode) or an operator button steps one phase (manual mode).
module traffic_light #(
    parameter int TICK_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw_led,
    input  logic        controll_led,
    input  logic        sw_mode,
    output logic [1:0]  led
);

    localparam int               PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    localparam logic [1:0] LED_RED    = 2'b11;
    localparam logic [1:0] LED_GREEN  = 2'b01;
    localparam logic [1:0] LED_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       led_q, led_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       rem_q, rem_d;
    logic             entry_q;
    logic             mode_q;
    logic             sync_p0, sync_p1, btn_p2;
    logic             tick, step, restart, advance;

    // A zero field still gives the phase one full tick.
    function automatic logic [3:0] phase_dur(input state_t s, input logic [11:0] sw);
        logic [3:0] f;
        case (s)
            S_GREEN:  f = sw[7:4];
            S_YELLOW: f = sw[3:0];
            default:  f = sw[11:8];
        endcase
        return (f == 4'd0) ? 4'd1 : f;
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            S_RED:   return S_GREEN;
            S_GREEN: return S_YELLOW;
            default: return S_RED;
        endcase
    endfunction

    // Button synchronizer (p0, p1) and edge register (p2)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            btn_p2  <= 1'b0;
        end else begin
            sync_p0 <= controll_led;
            sync_p1 <= sync_p0;
            btn_p2  <= sync_p1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RED;
            led_q   <= LED_RED;
            pre_q   <= '0;
            rem_q   <= 4'd1;
            entry_q <= 1'b1;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            entry_q <= 1'b0;
            mode_q  <= sw_mode;
        end
    end

    // restart: reset exit or manual->auto return; both reload the current phase
    always_comb begin
        tick    = !sw_mode && (pre_q == PRE_LAST);
        step    = sw_mode && sync_p1 && !btn_p2;
        restart = entry_q || (mode_q && !sw_mode);
        advance = !entry_q && (step || (!restart && tick && (rem_q == 4'd1)));
        state_d = advance ? next_phase(state_q) : state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        if (advance || restart) begin
            pre_d = '0;
            rem_d = phase_dur(state_d, sw_led);
        end else if (!sw_mode) begin
            if (tick) begin
                pre_d = '0;
                rem_d = rem_q - 4'd1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_comb begin
        case (state_d)
            S_GREEN:  led_d = LED_GREEN;
            S_YELLOW: led_d = LED_YELLOW;
            default:  led_d = LED_RED;
        endcase
    end

    assign led = led_q;

endmodule

// File: tb/tb_traffic_light.sv
`timescale 1ns/1ps
// tb_traffic_light: directed scenarios plus randomized switch/button activity,
// compared against a cycle-counting reference model of the light sequence.
module tb_traffic_light;
    localparam int T = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sw_led;
    logic        controll_led;
    logic        sw_mode;
    logic [1:0]  led;

    int checks = 0;
    int errors = 0;

    traffic_light #(.TICK_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .sw_led(sw_led),
        .controll_led(controll_led), .sw_mode(sw_mode), .led(led)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] lamp(input int p);
        case (p)
            0:       return 2'b11;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int dur_of(input int p, input logic [11:0] sw);
        int f;
        f = (int'(sw) >> (8 - 4 * p)) & 15;
        return (f == 0) ? 1 : f;
    endfunction

    // Reference model: phase index 0/1/2 and cycles left in the phase.
    int m_phase, m_left;
    bit m_init, m_mode_prev, h1, h2, h3;   // h1..h3: button seen 1..3 edges ago
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_left = 0; m_init = 1'b1; m_mode_prev = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            if (m_init) begin
                m_init = 1'b0;
                m_left = dur_of(0, sw_led) * T;
            end else if (sw_mode && h2 && !h3) begin
                m_phase = (m_phase + 1) % 3;
                m_left  = dur_of(m_phase, sw_led) * T;
            end else if (m_mode_prev && !sw_mode) begin
                m_left = dur_of(m_phase, sw_led) * T;
            end else if (!sw_mode) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = (m_phase + 1) % 3;
                    m_left  = dur_of(m_phase, sw_led) * T;
                end
            end
            m_mode_prev = sw_mode;
            h3 = h2; h2 = h1; h1 = controll_led;
        end
    end

    logic [1:0] run_val[$];
    int         run_len[$];

    task automatic observe(input int n);
        run_val.delete();
        run_len.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (run_val.size() == 0 || led !== run_val[$]) begin
                run_val.push_back(led);
                run_len.push_back(1);
            end else begin
                run_len[run_len.size() - 1]++;
            end
        end
    endtask

    task automatic do_reset(input logic [11:0] sw, input int n);
        rst = 1'b0; sw_led = sw; sw_mode = 1'b0; controll_led = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sw_led = 12'hFF2; sw_mode = 1'b0; controll_led = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 2'b11) begin
            errors++; $display("FAIL reset_led got=%b want=11", led);
        end
    endtask

    task automatic test_auto_cycle();
        logic [1:0] vals [3] = '{2'b11, 2'b01, 2'b10};
        int         lens [3] = '{150, 150, 20};
        do_reset(12'hFF2, 50);
        observe(4000);
        checks++;
        if (run_val.size() < 36) begin
            errors++; $display("FAIL auto_run_count got=%0d want>=36", run_val.size());
        end
        for (int i = 0; i < run_val.size() - 1; i++) begin
            checks++;
            if (run_val[i] !== vals[i % 3] || run_len[i] != lens[i % 3]) begin
                errors++;
                $display("FAIL auto_run[%0d] got=%b/%0d want=%b/%0d", i, run_val[i], run_len[i],
                         vals[i % 3], lens[i % 3]);
            end
        end
    endtask

    task automatic test_async_reset();
        int waited = 0;
        while (led !== 2'b01 && waited < 400) begin
            @(negedge clk); waited++;
        end
        checks++;
        if (led !== 2'b01) begin
            errors++; $display("FAIL async_wait_green got=%b want=01", led);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (led !== 2'b11) begin
            errors++; $display("FAIL async_reset_immediate got=%b want=11", led);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        observe(200);
        checks++;
        if (run_val.size() < 2 || run_val[0] !== 2'b11 || run_len[0] != 150 || run_val[1] !== 2'b01) begin
            errors++;
            $display("FAIL async_red_after_release runs=%0d first=%b/%0d want=11/150 then 01",
                     run_val.size(), run_val.size() > 0 ? run_val[0] : 2'bxx,
                     run_len.size() > 0 ? run_len[0] : -1);
        end
    endtask

    task automatic test_zero_duration();
        logic [1:0] vals [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        do_reset(12'h101, 3);
        observe(95);
        checks++;
        if (run_val.size() < 5) begin
            errors++; $display("FAIL zero_run_count got=%0d want>=5", run_val.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (run_val[i] !== vals[i] || run_len[i] != 10) begin
                    errors++;
                    $display("FAIL zero_run[%0d] got=%b/%0d want=%b/10", i, run_val[i], run_len[i], vals[i]);
                end
            end
        end
    endtask

    task automatic test_duration_sampling();
        logic [1:0] vals [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        int         lens [4] = '{100, 150, 20, 30};
        do_reset(12'hFF2, 3);
        observe(50);
        sw_led = 12'h3F2;
        observe(400);
        checks++;
        if (run_val.size() < 5) begin
            errors++; $display("FAIL sample_run_count got=%0d want>=5", run_val.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (run_val[i] !== vals[i] || run_len[i] != lens[i]) begin
                    errors++;
                    $display("FAIL sample_run[%0d] got=%b/%0d want=%b/%0d", i, run_val[i], run_len[i],
                             vals[i], lens[i]);
                end
            end
        end
    endtask

    task automatic test_manual();
        logic [1:0] seq [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        logic [1:0] last;
        int         changes;
        do_reset(12'hFF2, 3);
        repeat (20) @(negedge clk);
        sw_mode = 1'b1;
        repeat (5) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            controll_led = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c <= 3) begin
                    checks++;
                    if (led !== ((c < 3) ? seq[p] : seq[p + 1])) begin
                        errors++;
                        $display("FAIL manual_step%0d_cyc%0d got=%b want=%b", p, c, led,
                                 (c < 3) ? seq[p] : seq[p + 1]);
                    end
                end
            end
            controll_led = 1'b0;
            repeat (5) @(negedge clk);
        end
        changes = 0; last = led;
        repeat (1000) begin
            @(negedge clk);
            if (led !== last) changes++;
            last = led;
        end
        checks++;
        if (changes != 0 || led !== 2'b11) begin
            errors++; $display("FAIL manual_idle changes=%0d led=%b want=0/11", changes, led);
        end
        controll_led = 1'b1;
        changes = 0; last = led;
        repeat (100) begin
            @(negedge clk);
            if (led !== last) changes++;
            last = led;
        end
        checks++;
        if (changes != 1 || led !== 2'b01) begin
            errors++; $display("FAIL manual_hold changes=%0d led=%b want=1/01", changes, led);
        end
        controll_led = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_return_auto();
        sw_mode = 1'b0;
        observe(200);
        checks++;
        if (run_val.size() < 3 || run_val[0] !== 2'b01 || run_len[0] != 150 ||
            run_val[1] !== 2'b10 || run_len[1] != 20 || run_val[2] !== 2'b11) begin
            errors++;
            $display("FAIL return_auto runs=%0d first=%b/%0d want=01/150 10/20 11",
                     run_val.size(), run_val.size() > 0 ? run_val[0] : 2'bxx,
                     run_len.size() > 0 ? run_len[0] : -1);
        end
    endtask

    task automatic test_random();
        int act, len;
        do_reset(12'h312, 2);
        for (int seg = 0; seg < 160; seg++) begin
            act = $urandom_range(0, 11);
            len = $urandom_range(1, 30);
            if (act <= 1) begin
                sw_led = (act == 0) ? (12'($urandom) & 12'h333) : 12'($urandom);
            end else if (act <= 3) begin
                sw_mode = ~sw_mode;
            end else if (act <= 8) begin
                controll_led = ~controll_led;
            end else if (act == 9) begin
                #2 rst = 1'b0;
                #1;
                checks++;
                if (led !== lamp(m_phase)) begin
                    errors++; $display("FAIL random_async_reset got=%b want=%b", led, lamp(m_phase));
                end
                @(negedge clk);
                rst = 1'b1;
            end
            repeat (len) begin
                @(negedge clk);
                checks++;
                if (led !== lamp(m_phase)) begin
                    errors++;
                    $display("FAIL random_seg%0d led=%b want=%b t=%0t", seg, led, lamp(m_phase), $time);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_cycle();
        test_async_reset();
        test_zero_duration();
        test_duration_sampling();
        test_manual();
        test_return_auto();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
